// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// Buffered UART transmitter: valid/ready byte intake, power-of-two FIFO, and an
// 8N1/8N2 serialiser that chains frames back-to-back while bytes are queued.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 109,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [7:0]                  s_tdata,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          stop_end;

    // Ready looks only at the registered count, so a full FIFO never writes through.
    assign s_tready = (fifo_count != FULL);
    assign push     = s_tvalid && s_tready;
    assign stop_end = (state == STOP) && (bit_cnt == STOP_LAST);
    assign pop      = (fifo_count != '0) && ((state == IDLE) || stop_end);
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_tdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Shift register is pure data and is left out of the reset branch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            uart_tx <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            bit_cnt <= bit_cnt + CW'(1);
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        uart_tx <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        uart_tx <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            uart_tx <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        bit_cnt <= '0;
                        tx_done <= 1'b1;
                        if (pop) begin
                            shreg   <= mem[rd_ptr];
                            uart_tx <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_fifo: table of single frames plus hand-written
// sequences for back-to-back, FIFO-full, two-stop-bit and mid-frame reset cases.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready, uart_tx, tx_busy, tx_done;
    logic [2:0] fifo_count;
    logic [7:0] s_tdata_b = 8'h00;
    logic       s_tvalid_b = 1'b0;
    logic       s_tready_b, uart_tx_b, tx_busy_b, tx_done_b;
    logic [2:0] fifo_count_b;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] mon_q[$];
    int         mon_t[$];
    logic       mon_ok[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .rstn(rstn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .uart_tx(uart_tx), .tx_busy(tx_busy),
        .tx_done(tx_done), .fifo_count(fifo_count)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .rstn(rstn), .s_tdata(s_tdata_b), .s_tvalid(s_tvalid_b),
        .s_tready(s_tready_b), .uart_tx(uart_tx_b), .tx_busy(tx_busy_b),
        .tx_done(tx_done_b), .fifo_count(fifo_count_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_frames(input int n, input int limit);
        int w;
        w = 0;
        while (mon_q.size() < n && w < limit) begin
            tick();
            w++;
        end
        check("frames_seen", mon_q.size(), n);
    endtask

    task automatic mon_clear();
        mon_q.delete();
        mon_t.delete();
        mon_ok.delete();
    endtask

    // Independent serial decoder: samples each bit mid-period on the falling clock edge.
    initial begin : monitor
        logic [7:0] b;
        logic       ok;
        int         t0;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && uart_tx === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                repeat (2) @(negedge clk);
                if (uart_tx !== 1'b0) ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (uart_tx !== 1'b1) ok = 1'b0;
                mon_q.push_back(b);
                mon_t.push_back(t0);
                mon_ok.push_back(ok);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t       vecs[5];
        logic [7:0] seq[3];
        logic       rdy_exp[10];
        int         cnt_exp[10];
        logic       rdy;
        logic       bad;
        logic       exp_bit;
        int         nxt;
        int         w;
        int         c;

        // Line levels in transmit order, MSB first: start, d0..d7 (LSB first), stop.
        vecs[0] = '{8'h55, 10'b0101010101};
        vecs[1] = '{8'h3C, 10'b0001111001};
        vecs[2] = '{8'h00, 10'b0000000001};
        vecs[3] = '{8'hFF, 10'b0111111111};
        vecs[4] = '{8'hA3, 10'b0110001011};
        seq = '{8'hA3, 8'h0F, 8'hFF};
        rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cnt_exp = '{1, 1, 2, 3, 4, 4, 4, 4, 4, 4};

        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        check1("rst_uart_tx", uart_tx, 1'b1);
        check1("rst_s_tready", s_tready, 1'b1);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check1("rst_tx_busy", tx_busy, 1'b0);
        check1("rst_tx_done", tx_done, 1'b0);
        check1("rst_b_uart_tx", uart_tx_b, 1'b1);
        bad = 1'b0;
        repeat (50) begin
            tick();
            if (uart_tx !== 1'b1 || s_tready !== 1'b1 || fifo_count !== 3'd0 ||
                tx_busy !== 1'b0 || tx_done !== 1'b0) bad = 1'b1;
        end
        check1("idle_50_cycles_stable", bad, 1'b0);

        for (int v = 0; v < 5; v++) begin
            s_tdata  = vecs[v].data;
            s_tvalid = 1'b1;
            check1($sformatf("v%0d_ready", v), s_tready, 1'b1);
            tick();
            s_tvalid = 1'b0;
            check($sformatf("v%0d_count_after_push", v), 32'(fifo_count), 1);
            check1($sformatf("v%0d_line_before_start", v), uart_tx, 1'b1);
            tick();
            for (int t = 0; t < 40; t++) begin
                check1($sformatf("v%0d_line_c%0d", v, t), uart_tx, vecs[v].line[9 - t / CPB]);
                check1($sformatf("v%0d_done_c%0d", v, t), tx_done, 1'b0);
                check1($sformatf("v%0d_busy_c%0d", v, t), tx_busy, 1'b1);
                tick();
            end
            check1($sformatf("v%0d_done_pulse", v), tx_done, 1'b1);
            check1($sformatf("v%0d_line_idle", v), uart_tx, 1'b1);
            check1($sformatf("v%0d_busy_clear", v), tx_busy, 1'b0);
            check($sformatf("v%0d_count_empty", v), 32'(fifo_count), 0);
            tick();
            check1($sformatf("v%0d_done_single", v), tx_done, 1'b0);
        end

        // Three bytes on consecutive cycles chain with no idle gap.
        repeat (5) tick();
        mon_clear();
        for (int i = 0; i < 3; i++) begin
            s_tdata  = seq[i];
            s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        bad = 1'b0;
        repeat (115) begin
            if (tx_busy !== 1'b1) bad = 1'b1;
            tick();
        end
        check1("b2b_busy_continuous", bad, 1'b0);
        wait_frames(3, 200);
        if (mon_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b_byte%0d", i), 32'(mon_q[i]), 32'(seq[i]));
                check1($sformatf("b2b_framing%0d", i), mon_ok[i], 1'b1);
            end
            check("b2b_gap_1", mon_t[1] - mon_t[0], 40);
            check("b2b_gap_2", mon_t[2] - mon_t[1], 40);
        end

        // Streaming into a depth-4 FIFO: source holds the byte while stalled.
        repeat (5) tick();
        mon_clear();
        nxt = 0;
        for (int i = 0; i < 10; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(nxt);
            check1($sformatf("full_ready_c%0d", i), s_tready, rdy_exp[i]);
            rdy = s_tready;
            tick();
            if (rdy) nxt++;
            check($sformatf("full_count_c%0d", i), 32'(fifo_count), cnt_exp[i]);
        end
        w = 0;
        while (nxt < 7 && w < 200) begin
            s_tdata = 8'(nxt);
            rdy = s_tready;
            tick();
            if (rdy) nxt++;
            w++;
        end
        s_tvalid = 1'b0;
        check("full_drain_accepted", nxt, 7);
        wait_frames(7, 400);
        if (mon_q.size() >= 7) begin
            for (int i = 0; i < 7; i++) begin
                check($sformatf("full_order%0d", i), 32'(mon_q[i]), i);
                check1($sformatf("full_framing%0d", i), mon_ok[i], 1'b1);
            end
            for (int i = 1; i < 7; i++)
                check($sformatf("full_gap%0d", i), mon_t[i] - mon_t[i-1], 40);
        end

        // Two stop bits: 0x80 twice, 44-cycle frames with an 8-cycle high stop.
        repeat (5) tick();
        s_tdata_b  = 8'h80;
        s_tvalid_b = 1'b1;
        tick();
        tick();
        s_tvalid_b = 1'b0;
        for (int t = 0; t <= 88; t++) begin
            c = t % 44;
            if (t == 88) exp_bit = 1'b1;
            else if (c < 40) exp_bit = vecs[0].line[0] & 1'b0 | (10'b0000000011 >> (9 - c / CPB)) & 10'd1 ? 1'b1 : 1'b0;
            else exp_bit = 1'b1;
            check1($sformatf("stop2_line_c%0d", t), uart_tx_b, exp_bit);
            check1($sformatf("stop2_done_c%0d", t), tx_done_b, (t == 44 || t == 88));
            check1($sformatf("stop2_busy_c%0d", t), tx_busy_b, (t < 88));
            if (t < 88) tick();
        end

        // One-cycle reset in the middle of DATA with three bytes queued.
        repeat (5) tick();
        for (int i = 0; i < 4; i++) begin
            s_tdata  = 8'h11 * 8'(i + 1);
            s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        repeat (14) tick();
        check("mid_rst_count_before", 32'(fifo_count), 3);
        check1("mid_rst_busy_before", tx_busy, 1'b1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check1("mid_rst_uart_tx", uart_tx, 1'b1);
        check("mid_rst_fifo_count", 32'(fifo_count), 0);
        check1("mid_rst_tx_busy", tx_busy, 1'b0);
        check1("mid_rst_s_tready", s_tready, 1'b1);
        check1("mid_rst_tx_done", tx_done, 1'b0);
        bad = 1'b0;
        repeat (50) begin
            tick();
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check1("mid_rst_flushed_quiet", bad, 1'b0);
        mon_clear();
        s_tdata  = 8'h3C;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        wait_frames(1, 100);
        if (mon_q.size() >= 1) begin
            check("post_rst_byte", 32'(mon_q[0]), 32'h3C);
            check1("post_rst_framing", mon_ok[0], 1'b1);
        end

        repeat (10) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
